// File: rtl/button_conditioner.sv
// Per-channel button front end: two-flop synchroniser, stable-count debounce
// filter, clean active-low level and one-cycle press/release pulses.
module button_conditioner #(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = 270000,
    parameter int CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] button_raw,
    output logic [NUM_BUTTONS-1:0] button_clean,
    output logic [NUM_BUTTONS-1:0] press_pulse,
    output logic [NUM_BUTTONS-1:0] release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] sync1_q, sync1_d;
    logic [NUM_BUTTONS-1:0] sync2_q, sync2_d;
    logic [NUM_BUTTONS-1:0] clean_q, clean_d;
    logic [NUM_BUTTONS-1:0] press_q, press_d;
    logic [NUM_BUTTONS-1:0] release_q, release_d;
    logic [CNT_W-1:0]       cnt_q [NUM_BUTTONS];
    logic [CNT_W-1:0]       cnt_d [NUM_BUTTONS];

    // A channel is counting whenever its synchronised level differs from the
    // accepted level; any return to the accepted level discards the count.
    always_comb begin
        sync1_d   = button_raw;
        sync2_d   = sync1_q;
        clean_d   = clean_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    clean_d[i]   = sync2_q[i];
                    press_d[i]   = ~sync2_q[i];
                    release_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            clean_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign button_clean  = clean_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an 8-cycle debounce interval;
// an accepted change shows up on the 10th rising edge after the raw change.
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [1:0] button_raw;
    logic [1:0] button_clean;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;

    int errors = 0;
    int checks = 0;

    button_conditioner #(
        .NUM_BUTTONS    (2),
        .DEBOUNCE_CYCLES(8),
        .CNT_W          (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .button_raw   (button_raw),
        .button_clean (button_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        button_raw = 2'b11;
        repeat (3) @(negedge clk);
        checks++;
        if (button_clean !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: clean=%b press=%b release=%b, want 11/00/00",
                     button_clean, press_pulse, release_pulse);
        end
        rst = 1'b0;
        for (int e = 1; e <= 50; e++) begin
            tick();
            checks++;
            if (button_clean !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL reset_idle edge %0d: clean=%b press=%b release=%b, want 11/00/00",
                         e, button_clean, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_glitch();
        button_raw[0] = 1'b0;
        repeat (5) tick();
        button_raw[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++;
            if (button_clean !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL glitch edge %0d: clean=%b press=%b release=%b, want 11/00/00",
                         e, button_clean, press_pulse, release_pulse);
            end
        end
    endtask

    task automatic test_press();
        logic [1:0] exp_clean;
        logic [1:0] exp_press;
        button_raw[0] = 1'b0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_clean = (e >= 10) ? 2'b10 : 2'b11;
            exp_press = (e == 10) ? 2'b01 : 2'b00;
            checks++;
            if (button_clean !== exp_clean || press_pulse !== exp_press || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL press edge %0d: clean=%b press=%b release=%b, want %b/%b/00",
                         e, button_clean, press_pulse, release_pulse, exp_clean, exp_press);
            end
        end
    endtask

    task automatic test_release();
        logic [1:0] exp_clean;
        logic [1:0] exp_rel;
        button_raw[0] = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            tick();
            exp_clean = (e >= 10) ? 2'b11 : 2'b10;
            exp_rel   = (e == 10) ? 2'b01 : 2'b00;
            checks++;
            if (button_clean !== exp_clean || release_pulse !== exp_rel || press_pulse !== 2'b00) begin
                errors++;
                $display("FAIL release edge %0d: clean=%b press=%b release=%b, want %b/00/%b",
                         e, button_clean, press_pulse, release_pulse, exp_clean, exp_rel);
            end
        end
    endtask

    task automatic test_bounce();
        logic [1:0] exp_clean;
        logic [1:0] exp_press;
        int         press_seen;
        for (int c = 0; c < 40; c++) begin
            button_raw[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (button_clean !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL bounce cycle %0d: clean=%b press=%b release=%b, want 11/00/00",
                         c, button_clean, press_pulse, release_pulse);
            end
        end
        button_raw[1] = 1'b0;
        press_seen = 0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (press_pulse[1] === 1'b1) press_seen++;
            exp_clean = (e >= 10) ? 2'b01 : 2'b11;
            exp_press = (e == 10) ? 2'b10 : 2'b00;
            checks++;
            if (button_clean !== exp_clean || press_pulse !== exp_press || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL bounce_settle edge %0d: clean=%b press=%b release=%b, want %b/%b/00",
                         e, button_clean, press_pulse, release_pulse, exp_clean, exp_press);
            end
        end
        checks++;
        if (press_seen != 1) begin
            errors++;
            $display("FAIL bounce_press_count: got %0d pulses, want 1", press_seen);
        end
    endtask

    // Channel 1 is held pressed here; channel 0 is pressed and reset at count 5.
    task automatic test_reset_mid();
        logic [1:0] exp_clean;
        logic [1:0] exp_press;
        button_raw[0] = 1'b0;
        repeat (7) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (button_clean !== 2'b11 || press_pulse !== 2'b00 || release_pulse !== 2'b00) begin
            errors++;
            $display("FAIL reset_async: clean=%b press=%b release=%b, want 11/00/00",
                     button_clean, press_pulse, release_pulse);
        end
        @(negedge clk);
        repeat (2) tick();
        checks++;
        if (button_clean !== 2'b11 || press_pulse !== 2'b00) begin
            errors++;
            $display("FAIL reset_held: clean=%b press=%b, want 11/00", button_clean, press_pulse);
        end
        rst = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            exp_clean = (e >= 10) ? 2'b00 : 2'b11;
            exp_press = (e == 10) ? 2'b11 : 2'b00;
            checks++;
            if (button_clean !== exp_clean || press_pulse !== exp_press || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL after_reset edge %0d: clean=%b press=%b release=%b, want %b/%b/00",
                         e, button_clean, press_pulse, release_pulse, exp_clean, exp_press);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_clean;
        logic [1:0] exp_pulse;
        button_raw = 2'b11;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_clean = (e >= 10) ? 2'b11 : 2'b00;
            exp_pulse = (e == 10) ? 2'b11 : 2'b00;
            checks++;
            if (button_clean !== exp_clean || release_pulse !== exp_pulse || press_pulse !== 2'b00) begin
                errors++;
                $display("FAIL sim_release edge %0d: clean=%b press=%b release=%b, want %b/00/%b",
                         e, button_clean, press_pulse, release_pulse, exp_clean, exp_pulse);
            end
        end
        button_raw = 2'b00;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_clean = (e >= 10) ? 2'b00 : 2'b11;
            exp_pulse = (e == 10) ? 2'b11 : 2'b00;
            checks++;
            if (button_clean !== exp_clean || press_pulse !== exp_pulse || release_pulse !== 2'b00) begin
                errors++;
                $display("FAIL sim_press edge %0d: clean=%b press=%b release=%b, want %b/%b/00",
                         e, button_clean, press_pulse, release_pulse, exp_clean, exp_pulse);
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_press();
        test_release();
        test_bounce();
        test_reset_mid();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front end for the LED control stage. It conditions the raw, active-low board buttons before they reach the controller.
- Per channel it does three things: synchronises the raw pin into clk with two flops, debounces it with a stable-count filter, and emits clean active-low levels plus one-cycle press/release event pulses.
- Its outputs replace the raw button pins at the control stage's button inputs.

Parameters:
- NUM_BUTTONS, 2, number of independent button channels.
- DEBOUNCE_CYCLES, 270000, consecutive stable cycles required before a level change is accepted (10 ms at 27 MHz). Legal range is >= 1.
- CNT_W, 20, per-channel counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state is rising-edge clocked.
- rst  input  1  asynchronous, active-high reset.
- button_raw  input  NUM_BUTTONS  raw pins, active-low (0 = pressed), asynchronous to clk.
- button_clean  output  NUM_BUTTONS  debounced level, active-low, drop-in replacement for the raw pins.
- press_pulse  output  NUM_BUTTONS  1-cycle high when the clean level goes 1->0.
- release_pulse  output  NUM_BUTTONS  1-cycle high when the clean level goes 0->1.

Behaviour:
- Reset (rst=1, asynchronous assert; release is sampled on clk):
  - Both sync flops of each channel = 1.
  - button_clean = all 1s (released).
  - Counters = 0.
  - press_pulse = release_pulse = 0.
- Synchroniser: sync1 <= button_raw; sync2 <= sync1. Only sync2 feeds the filter. No logic on sync1.
- Filter, per channel, independent. Each channel has two states, STABLE and COUNTING. The state is implicit: the channel is COUNTING when sync2 != button_clean.
  - sync2 == button_clean: counter <= 0; no pulse.
  - sync2 != button_clean and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != button_clean and counter == DEBOUNCE_CYCLES-1:
    - button_clean <= sync2; counter <= 0.
    - Assert the matching pulse for exactly this one cycle.
    - press_pulse if sync2 = 0; release_pulse if sync2 = 1.
- Glitch rejection: if sync2 returns to the clean level at any count, the counter clears to 0. There is no partial credit and no output change.
- Latency: for a raw level change held stable, button_clean and the pulse update on rising edge DEBOUNCE_CYCLES+2. Edge 1 is the first edge that captures the new level into sync1.
  - Example: DEBOUNCE_CYCLES=8 gives edge 10.
- Pulses are registered and high for exactly one cycle per accepted transition. press_pulse and release_pulse are never high together on the same channel.
- Counter never exceeds DEBOUNCE_CYCLES-1, so it has no wrap-around.
- Simultaneous events: channels share no state. Different channels may pulse in the same cycle.
- Reset mid-operation: the count is discarded and outputs return to reset values immediately, without waiting for clk. If the raw pin is still low after reset, the full debounce interval applies again before a press is reported.
- A held button produces one press_pulse only, with no repeat. The release_pulse comes after release plus the debounce interval.

Test Plan (DEBOUNCE_CYCLES=8, CNT_W=4, NUM_BUTTONS=2):
- Reset release with both raw=1 -> button_clean=2'b11, pulses 0, held for 50 cycles.
- Drive raw[0]=0 and hold -> on edge 10: button_clean[0]=0 and press_pulse[0]=1 for one cycle. Channel 1 stays unchanged.
- Drive raw[0]=0 for 5 cycles, then 1 -> button_clean[0] stays 1 and no pulse occurs.
- Bounce raw[1] 0/1 every 3 cycles for 40 cycles, then hold 0 -> no pulses during bouncing. press_pulse[1] fires exactly once, 10 edges after the final settle.
- With button_clean[0]=0, release raw[0]=1 and hold -> release_pulse[0] fires one cycle on edge 10 and button_clean[0]=1. press_pulse[0] stays 0.
- Hold raw[0]=0 and assert rst at count 5 for 2 cycles (asynchronous, mid-cycle) -> outputs go to reset values immediately. After release, press_pulse[0] fires 10 edges after the first sampling edge. Both channels pressed on the same cycle -> both press_pulse bits are high in the same cycle.
